ps2_mouse_receiver: RTL and testbench
=====================================

PS2_MOUSE_RECEIVER -- requirements
Module: ps2_mouse_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the CLK cycles allowed between PS/2 clock falling edges inside a frame (0.5 ms at 100 MHz).
REQ-002 Parameter FILTER_LEN, default 8, is the number of consecutive equal samples needed to accept a CLK_MOUSE_IN level (used only under REQ-026).
REQ-003 CLK  input  1  system clock; all logic on its rising edge; one clock domain.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CLK_MOUSE_IN  input  1  raw PS/2 clock line from the mouse, asynchronous.
REQ-006 DATA_MOUSE_IN  input  1  raw PS/2 data line from the mouse, asynchronous.
REQ-007 READ_ENABLE  input  1  high = receiver armed; low = frames ignored.
REQ-008 BYTE_READ  output  8  last received data byte.
REQ-009 BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error, for the last frame.
REQ-010 BYTE_READY  output  1  one-cycle strobe: BYTE_READ and BYTE_ERROR_CODE are valid.

Function
REQ-011 Both inputs pass through a 2-flop synchronizer; a falling edge is flagged when the synchronized clock was 1 in the previous cycle and is 0 in the current one.
REQ-012 Data is sampled from synchronized DATA_MOUSE_IN in the same cycle a falling edge is flagged.
REQ-013 States: IDLE, DATA, PARITY, STOP, DONE.
REQ-014 IDLE: on a falling edge with READ_ENABLE=1 and data=0 (start bit), go to DATA with bit counter=0. With data=1 or READ_ENABLE=0, stay in IDLE.
REQ-015 DATA: each falling edge shifts data LSB-first into BYTE_READ[counter] and increments a 3-bit counter; the edge that stores bit 7 goes to PARITY.
REQ-016 PARITY: on a falling edge, BYTE_ERROR_CODE[0] = 1 when the 8 data bits plus the parity bit hold an even number of ones (odd parity violated), else 0; go to STOP.
REQ-017 STOP: on a falling edge, BYTE_ERROR_CODE[1] = ~data; go to DONE.
REQ-018 DONE: BYTE_READY=1 for exactly this one cycle; then IDLE unconditionally. BYTE_READY is therefore high one cycle after the stop-bit edge is flagged.
REQ-019 A frame with errors still produces BYTE_READY; the consumer decides from BYTE_ERROR_CODE.
REQ-020 Timeout counter clears on every flagged edge and in IDLE, and increments otherwise. When it reaches TIMEOUT_CYCLES in DATA, PARITY or STOP, return to IDLE with no BYTE_READY; BYTE_READ and BYTE_ERROR_CODE are unchanged.
REQ-021 READ_ENABLE falling mid-frame does not abort the frame; it only gates the start condition.
REQ-022 BYTE_READ and BYTE_ERROR_CODE hold their values between frames and are updated only by bit captures.
REQ-023 Back-to-back frames are accepted: the start-bit edge of the next frame is recognised in the cycle after DONE.

Reset
REQ-024 RESET=1 at a rising CLK edge forces state IDLE, bit counter 0, timeout counter 0, synchronizer and filter flops to 1, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00 and BYTE_READY=0.
REQ-025 Reset mid-frame discards the partial frame. After RESET deasserts, the receiver waits for a fresh start bit, with no spurious edge caused by the flop preset.

Configuration
REQ-026 PS2_RX_GLITCH_FILTER_EN defined: after the synchronizer, the clock line changes its accepted level only after FILTER_LEN consecutive identical samples. Edge flags and BYTE_READY are delayed by FILTER_LEN cycles, and pulses shorter than FILTER_LEN cycles are ignored.
REQ-027 PS2_RX_GLITCH_FILTER_EN undefined: no filter; the edge detector uses the synchronizer output directly; FILTER_LEN is unused.

Verification
REQ-028 Frame for 8'h08 (start 0, bits 0001_0000 LSB-first, parity 0, stop 1) at a 60 us PS/2 period, READ_ENABLE=1 -> one BYTE_READY pulse, BYTE_READ=8'h08, BYTE_ERROR_CODE=2'b00.
REQ-029 Frame for 8'hFA with parity bit 0 (should be 1) -> BYTE_READY pulse, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b01.
REQ-030 Frame for 8'h00 with parity 1 and stop bit 0 -> BYTE_ERROR_CODE=2'b10; a following valid 8'hAA frame -> BYTE_READ=8'hAA, code 2'b00.
REQ-031 Clock stops after 4 data bits for more than TIMEOUT_CYCLES -> no BYTE_READY and state IDLE; the next full frame for 8'h3C is received correctly.
REQ-032 RESET pulsed for 1 cycle after bit 5 of a frame, then a frame for 8'h55 -> outputs reset to zero, exactly one BYTE_READY with 8'h55. A frame sent while READ_ENABLE=0 -> no BYTE_READY.
REQ-033 With PS2_RX_GLITCH_FILTER_EN: a 3-cycle low glitch on CLK_MOUSE_IN in IDLE, data=0 -> no state change. Without the macro, the same glitch -> the frame starts (state DATA).

Source files
------------

// File: rtl/ps2_mouse_receiver.sv
// rtl/ps2_mouse_receiver.sv - PS/2 mouse byte receiver (start/8 data/odd parity/stop) with frame timeout.
// Optional clock-line glitch filter enabled by defining PS2_RX_GLITCH_FILTER_EN.
module ps2_mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic            clk_prev_q, clk_prev_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic [1:0]      err_q, err_d;
  logic            clk_line;
  logic            fall;
  logic            timed_out;

`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // The accepted level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign clk_line = filt_q;
`else
  assign clk_line = clk_s2_q;
`endif

  assign fall      = clk_prev_q & ~clk_line;
  assign timed_out = (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    clk_s1_d   = CLK_MOUSE_IN;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = DATA_MOUSE_IN;
    dat_s2_d   = dat_s1_q;
    clk_prev_d = clk_line;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_d     = byte_q;
    err_d      = err_q;
    to_cnt_d   = fall ? '0 : to_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fall && READ_ENABLE && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          byte_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      PARITY: begin
        if (fall) begin
          // Odd parity: an even count of ones over data plus parity bit is an error.
          err_d[0] = ~(^{byte_q, dat_s2_q});
          state_d  = STOP;
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      STOP: begin
        if (fall) begin
          err_d[1] = ~dat_s2_q;
          state_d  = DONE;
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      bit_cnt_q  <= 3'd0;
      to_cnt_q   <= '0;
      byte_q     <= 8'h00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
    end
  end

  assign BYTE_READ       = byte_q;
  assign BYTE_ERROR_CODE = err_q;
  assign BYTE_READY      = (state_q == DONE);

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// tb/tb_ps2_mouse_receiver.sv - self-checking bench for ps2_mouse_receiver.
module tb_ps2_mouse_receiver;

  localparam int TO = 100;
  localparam int FL = 8;
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int LAT   = 3 + FL;
  localparam int TIGHT = 2 * FL;
`else
  localparam int LAT   = 3;
  localparam int TIGHT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] cap_q[$];
  int ready_cyc = 0;
  int stop_cyc = 0;

  always @(negedge CLK) begin
    if (BYTE_READY === 1'b1) begin
      cap_q.push_back({BYTE_ERROR_CODE, BYTE_READ});
      ready_cyc = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wcyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int first, input int n,
                           input int hi, input int lo);
    for (int i = first; i < first + n; i++) begin
      DATA_MOUSE_IN = bits[i];
      wcyc(hi);
      CLK_MOUSE_IN = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wcyc(lo);
      CLK_MOUSE_IN = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic par, input logic stp);
    return {stp, par, b, 1'b0};
  endfunction

  // Expected {error code, byte}: parity error when data plus parity bit hold an even count of ones.
  function automatic logic [9:0] model(input logic [7:0] b, input logic par, input logic stp);
    logic e0;
    e0 = ((($countones(b) + int'(par)) % 2) == 0);
    return {~stp, e0, b};
  endfunction

  task automatic test_reset;
    RESET = 1'b1;
    wcyc(3);
    vectors++;
    if ({BYTE_ERROR_CODE, BYTE_READ, BYTE_READY} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 000", {BYTE_ERROR_CODE, BYTE_READ, BYTE_READY});
    end
    RESET = 1'b0;
    wcyc(20);
    vectors++;
    if (cap_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_spurious_ready: got %0d pulses expected 0", cap_q.size());
    end
  endtask

  task automatic test_basic;
    cap_q.delete();
    send_bits(frame(8'h08, 1'b0, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d expected 1", cap_q.size());
    end else begin
      vectors++;
      if (cap_q[0] !== {2'b00, 8'h08}) begin
        miscompares++;
        $display("FAIL basic_byte: got %h expected %h", cap_q[0], {2'b00, 8'h08});
      end
      vectors++;
      if (ready_cyc - stop_cyc != LAT) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d expected %0d", ready_cyc - stop_cyc, LAT);
      end
    end
  endtask

  task automatic test_parity_error;
    cap_q.delete();
    send_bits(frame(8'hFA, 1'b0, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b01, 8'hFA}) begin
      miscompares++;
      $display("FAIL parity_error: got %0d pulses last %h expected 1 pulse %h",
               cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, {2'b01, 8'hFA});
    end
  endtask

  task automatic test_stop_error;
    cap_q.delete();
    send_bits(frame(8'h00, 1'b1, 1'b0), 0, 11, 20, 20);
    wcyc(20 + FL);
    send_bits(frame(8'hAA, 1'b1, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 2) begin
      miscompares++;
      $display("FAIL stop_error_count: got %0d expected 2", cap_q.size());
    end else begin
      vectors++;
      if (cap_q[0] !== {2'b10, 8'h00}) begin
        miscompares++;
        $display("FAIL stop_error_code: got %h expected %h", cap_q[0], {2'b10, 8'h00});
      end
      vectors++;
      if (cap_q[1] !== {2'b00, 8'hAA}) begin
        miscompares++;
        $display("FAIL stop_error_recover: got %h expected %h", cap_q[1], {2'b00, 8'hAA});
      end
    end
  endtask

  task automatic test_timeout;
    logic [7:0] partial;
    partial = 8'h05;
    cap_q.delete();
    send_bits(frame(partial, 1'b1, 1'b1), 0, 5, 20, 20);
    wcyc(TO + 60);
    vectors++;
    if (cap_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_no_ready: got %0d expected 0", cap_q.size());
    end
    vectors++;
    if ({BYTE_ERROR_CODE, BYTE_READ} !== {2'b00, 4'hA, partial[3:0]}) begin
      miscompares++;
      $display("FAIL timeout_hold: got %h expected %h", {BYTE_ERROR_CODE, BYTE_READ},
               {2'b00, 4'hA, partial[3:0]});
    end
    send_bits(frame(8'h3C, 1'b1, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b00, 8'h3C}) begin
      miscompares++;
      $display("FAIL timeout_next_frame: got %0d pulses last %h expected 1 pulse %h",
               cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, {2'b00, 8'h3C});
    end
  endtask

  task automatic test_reset_midframe;
    cap_q.delete();
    send_bits(frame(8'hC3, 1'b1, 1'b1), 0, 7, 20, 20);
    RESET = 1'b1;
    wcyc(1);
    RESET = 1'b0;
    vectors++;
    if ({BYTE_ERROR_CODE, BYTE_READ, BYTE_READY} !== 11'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h expected 000", {BYTE_ERROR_CODE, BYTE_READ, BYTE_READY});
    end
    wcyc(20);
    send_bits(frame(8'h55, 1'b1, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b00, 8'h55}) begin
      miscompares++;
      $display("FAIL midreset_frame: got %0d pulses last %h expected 1 pulse %h",
               cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, {2'b00, 8'h55});
    end
    READ_ENABLE = 1'b0;
    send_bits(frame(8'h81, 1'b1, 1'b1), 0, 11, 20, 20);
    wcyc(20 + FL);
    READ_ENABLE = 1'b1;
    vectors++;
    if (cap_q.size() != 1) begin
      miscompares++;
      $display("FAIL disabled_no_ready: got %0d pulses expected 1", cap_q.size());
    end
    vectors++;
    if (BYTE_READ !== 8'h55) begin
      miscompares++;
      $display("FAIL disabled_hold: got %h expected 55", BYTE_READ);
    end
  endtask

  task automatic test_enable_midframe;
    logic [10:0] f;
    f = frame(8'h9E, 1'b0, 1'b1);
    cap_q.delete();
    send_bits(f, 0, 1, 20, 20);
    READ_ENABLE = 1'b0;
    send_bits(f, 1, 10, 20, 20);
    READ_ENABLE = 1'b1;
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0] !== model(8'h9E, 1'b0, 1'b1)) begin
      miscompares++;
      $display("FAIL enable_midframe: got %0d pulses last %h expected 1 pulse %h",
               cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, model(8'h9E, 1'b0, 1'b1));
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1, b2;
    logic p1, p2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    p1 = 1'($urandom);
    p2 = 1'($urandom);
    cap_q.delete();
    send_bits(frame(b1, p1, 1'b1), 0, 10, 20, 20);
    DATA_MOUSE_IN = 1'b1;
    wcyc(20);
    CLK_MOUSE_IN = 1'b0;
    wcyc(TIGHT);
    CLK_MOUSE_IN = 1'b1;
    DATA_MOUSE_IN = 1'b0;
    wcyc(TIGHT);
    CLK_MOUSE_IN = 1'b0;
    wcyc(20);
    CLK_MOUSE_IN = 1'b1;
    send_bits(frame(b2, p2, 1'b1), 1, 10, 20, 20);
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected 2", cap_q.size());
    end else begin
      vectors++;
      if (cap_q[0] !== model(b1, p1, 1'b1) || cap_q[1] !== model(b2, p2, 1'b1)) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h expected %h %h", cap_q[0], cap_q[1],
                 model(b1, p1, 1'b1), model(b2, p2, 1'b1));
      end
    end
  endtask

  task automatic test_glitch;
    logic [10:0] f;
    f = frame(8'h6B, 1'b0, 1'b1);
    cap_q.delete();
    DATA_MOUSE_IN = 1'b0;
    wcyc(3);
    CLK_MOUSE_IN = 1'b0;
    wcyc(3);
    CLK_MOUSE_IN = 1'b1;
    wcyc(20);
`ifdef PS2_RX_GLITCH_FILTER_EN
    send_bits(f, 0, 11, 20, 20);
`else
    send_bits(f, 1, 10, 20, 20);
`endif
    wcyc(20 + FL);
    vectors++;
    if (cap_q.size() != 1 || cap_q[0] !== {2'b00, 8'h6B}) begin
      miscompares++;
      $display("FAIL glitch: got %0d pulses last %h expected 1 pulse %h",
               cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, {2'b00, 8'h6B});
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic p, s;
    int hi, lo;
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      p  = 1'($urandom);
      s  = ($urandom_range(0, 3) != 0);
      hi = $urandom_range(12, 45);
      lo = $urandom_range(12, 45);
      cap_q.delete();
      send_bits(frame(b, p, s), 0, 11, hi, lo);
      wcyc(20 + FL);
      vectors++;
      if (cap_q.size() != 1 || cap_q[0] !== model(b, p, s)) begin
        miscompares++;
        $display("FAIL random_%0d: got %0d pulses last %h expected 1 pulse %h",
                 n, cap_q.size(), {BYTE_ERROR_CODE, BYTE_READ}, model(b, p, s));
      end
    end
  endtask

  initial begin
    RESET         = 1'b1;
    CLK_MOUSE_IN  = 1'b1;
    DATA_MOUSE_IN = 1'b1;
    READ_ENABLE   = 1'b1;
    test_reset();
    test_basic();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_reset_midframe();
    test_enable_midframe();
    test_back_to_back();
    test_glitch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
